prog_loader_r0: RTL and testbench

Boot-time instruction loader that sits directly upstream of the pipelined MIPS datapath's program memory. It accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them sequentially into program memory from word address 0 and holds the core in reset until a complete, checksum-verified image has been loaded.

---
 rtl/prog_loader_r0.sv | 156 +++++++++++++++
 tb/tb_prog_loader_r0.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_r0.sv
// Boot loader: takes a length-framed, XOR-checksummed byte stream, writes big-endian
// instruction words into program memory from address 0 and releases the core once verified.
module prog_loader_r0 #(
  parameter int BIT_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [BIT_WIDTH-1:0]      mem_wr_data,
  output logic                      core_hold,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'(2 ** MEM_ADDR_WIDTH);

  state_t                    state_q, state_d;
  logic [LEN_WIDTH-9:0]      len_hi_q, len_hi_d;
  logic [MEM_ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]                bcnt_q, bcnt_d;
  logic [BIT_WIDTH-9:0]      asm_q, asm_d;
  logic [7:0]                xor_q, xor_d;
  logic                      wr_en_q, wr_en_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BIT_WIDTH-1:0]      wr_data_q, wr_data_d;

  logic [LEN_WIDTH-1:0] len_new;
  logic                 accept;
  logic                 too_long;
  logic                 word_end;
  logic                 last_word;

  assign len_new   = {len_hi_q, in_data};
  assign too_long  = 32'(len_new) > MAX_WORDS;
  assign accept    = in_valid && in_ready;
  assign word_end  = (bcnt_q == 2'd3);
  assign last_word = (idx_q == last_idx_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_LEN_HI;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LEN_HI;
    end else if (accept) begin
      case (state_q)
        S_LEN_HI: state_d = S_LEN_LO;
        S_LEN_LO: begin
          if (len_new == '0)  state_d = S_CSUM;
          else if (too_long)  state_d = S_ERR;
          else                state_d = S_DATA;
        end
        S_DATA:   if (word_end && last_word) state_d = S_CSUM;
        S_CSUM:   state_d = (in_data == xor_q) ? S_DONE : S_ERR;
        default:  state_d = state_q;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready    = rst && !start &&
                  (state_q == S_LEN_HI || state_q == S_LEN_LO ||
                   state_q == S_DATA   || state_q == S_CSUM);
    core_hold   = (state_q != S_DONE);
    done        = (state_q == S_DONE);
    error       = (state_q == S_ERR);
    mem_wr_en   = wr_en_q;
    mem_wr_addr = wr_addr_q;
    mem_wr_data = wr_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_hi_q   <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      xor_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      len_hi_q   <= len_hi_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      xor_q      <= xor_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Word assembly, checksum and write-port registers; the index wraps only after a full-memory image
  always_comb begin
    len_hi_d   = len_hi_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    xor_d      = xor_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (start) begin
      idx_d  = '0;
      bcnt_d = '0;
      xor_d  = '0;
    end else if (accept) begin
      case (state_q)
        S_LEN_HI: len_hi_d = in_data;
        S_LEN_LO: last_idx_d = len_new[MEM_ADDR_WIDTH-1:0] - MEM_ADDR_WIDTH'(1);
        S_DATA: begin
          xor_d = xor_q ^ in_data;
          if (word_end) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = {asm_q, in_data};
            idx_d     = idx_q + MEM_ADDR_WIDTH'(1);
            bcnt_d    = '0;
          end else begin
            asm_d  = {asm_q[BIT_WIDTH-17:0], in_data};
            bcnt_d = bcnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader_r0.sv
// Scoreboard bench for prog_loader_r0: stimulus queues expected writes, a monitor checks
// every mem_wr_en pulse against them; status outputs are checked after each frame.
module tb_prog_loader_r0;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          core_hold;
  logic          done;
  logic          error;

  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int prev_wr;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_exp;
  logic [31:0]    frame_words[$];

  always #5 clk = ~clk;

  prog_loader_r0 #(.BIT_WIDTH(32), .MEM_ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .core_hold   (core_hold),
    .done        (done),
    .error       (error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst && mem_wr_en === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%08h expected none", mem_wr_addr, mem_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("write addr=%0d data=%08h", mem_wr_addr, mem_wr_data);
        check("wr_addr", 64'(mem_wr_addr), 64'(mon_exp[AW+31:32]));
        check("wr_data", 64'(mem_wr_data), 64'(mon_exp[31:0]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is consumed
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout: byte %02h not accepted within 20 cycles", b);
    end
  endtask

  task automatic gap_wait(input bit gap);
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int n, input bit gap, input bit bad_csum);
    logic [7:0]  cs;
    logic [15:0] len;
    logic [31:0] w;
    cs  = 8'h00;
    len = 16'(n);
    $display("frame len=%0d gap=%0d bad_csum=%0d", n, gap, bad_csum);
    send_byte(len[15:8]); gap_wait(gap);
    send_byte(len[7:0]);  gap_wait(gap);
    for (int i = 0; i < n; i++) begin
      w = frame_words[i];
      exp_q.push_back({AW'(i), w});
      for (int k = 3; k >= 0; k--) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8]);
        gap_wait(gap);
      end
    end
    send_byte(bad_csum ? (cs ^ 8'h01) : cs);
  endtask

  task automatic pulse_start(input bit with_valid, input logic [7:0] b);
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = b;
    @(negedge clk);
    check("ready_low_during_start", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic hold, input logic dn,
                              input logic er, input logic rdy);
    @(negedge clk);
    $display("status %s: hold=%0b done=%0b error=%0b ready=%0b", tag, core_hold, done, error, in_ready);
    check({tag, "_core_hold"}, 64'(core_hold), 64'(hold));
    check({tag, "_done"},      64'(done),      64'(dn));
    check({tag, "_error"},     64'(error),     64'(er));
    check({tag, "_in_ready"},  64'(in_ready),  64'(rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_core_hold", 64'(core_hold), 64'(1));
    check("rst_done",      64'(done),      64'(0));
    check("rst_error",     64'(error),     64'(0));
    check("rst_wr_en",     64'(mem_wr_en), 64'(0));
    check("rst_wr_addr",   64'(mem_wr_addr), 64'(0));
    check("rst_wr_data",   64'(mem_wr_data), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    check_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b1);

    // Valid 2-word frame, continuous bytes; checksum 0x28
    frame_words = '{32'h3C010010, 32'h20210004};
    send_frame(2, 1'b0, 1'b0);
    check_status("valid2", 1'b0, 1'b1, 1'b0, 1'b0);

    // Same frame, bad checksum, in_valid toggling
    pulse_start(1'b0, 8'h00);
    check_status("rearm1", 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(2, 1'b1, 1'b1);
    check_status("badcsum", 1'b1, 1'b0, 1'b1, 1'b0);
    check_status("badcsum_hold", 1'b1, 1'b0, 1'b1, 1'b0);

    // Abort midway through word 1 with start and in_valid together
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({AW'(0), 32'h3C010010});
    send_byte(8'h3C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h21);
    pulse_start(1'b1, 8'h00);
    check_status("abort", 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(2, 1'b0, 1'b0);
    check_status("resend", 1'b0, 1'b1, 1'b0, 1'b0);

    // Restart after done, then a 1-word frame (checksum 0x00)
    pulse_start(1'b0, 8'h00);
    check_status("restart", 1'b1, 1'b0, 1'b0, 1'b1);
    frame_words = '{32'hAABBCCDD};
    send_frame(1, 1'b0, 1'b0);
    check_status("one_word", 1'b0, 1'b1, 1'b0, 1'b0);

    // N = 0
    pulse_start(1'b0, 8'h00);
    prev_wr = wr_seen;
    frame_words = {};
    send_frame(0, 1'b0, 1'b0);
    check_status("n0", 1'b0, 1'b1, 1'b0, 1'b0);
    check("n0_write_count", 64'(wr_seen - prev_wr), 64'(0));

    // N = 65 exceeds capacity: error right after LEN_LO
    pulse_start(1'b0, 8'h00);
    prev_wr = wr_seen;
    send_byte(8'h00);
    send_byte(8'h41);
    check_status("n65", 1'b1, 1'b0, 1'b1, 1'b0);
    check("n65_write_count", 64'(wr_seen - prev_wr), 64'(0));

    // N = 64 fills memory exactly
    pulse_start(1'b0, 8'h00);
    prev_wr = wr_seen;
    frame_words = {};
    for (int i = 0; i < 64; i++)
      frame_words.push_back({8'(i), 8'(i) ^ 8'h55, 8'hA0, 8'(i * 3)});
    send_frame(64, 1'b0, 1'b0);
    check_status("n64", 1'b0, 1'b1, 1'b0, 1'b0);
    check("n64_write_count", 64'(wr_seen - prev_wr), 64'(64));

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
